logic_functions_tester: RTL and testbench

//  Hardware self-test sequencer for the logic_functions datapath (A,B,C -> O1,O2).
//  On start it drives all 8 input combinations in turn and waits a settle time.
//  It compares O1/O2 to golden O1=AC+A'B and O2=(A+C')(BC), counts mismatches and reports pass/fail.
//  It sits between board controls (button/switch) and the logic_functions instance, with results shown on LEDs.

---
 rtl/logic_functions_tester.sv | 113 +++++++++++
 tb/tb_logic_functions_tester.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/logic_functions_tester.sv
// Self-test sequencer for the logic_functions block (A,B,C -> O1,O2).
// On start it walks all eight {a,b,c} combinations. It holds each one for a
// settle time, then compares O1/O2 against the golden equations. It
// accumulates the mismatch count and records the first failing vector.
module logic_functions_tester #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       o1,
  input  logic       o2,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [2:0] first_fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [2:0] vec;
  logic [3:0] settle_cnt;
  logic       seen_fail;
  logic [1:0] golden;
  logic [4:0] mism;
  logic [4:0] err_next;

  // Golden response of logic_functions: {O1, O2} for a given {a,b,c}.
  function automatic logic [1:0] golden_out(input logic [2:0] v);
    logic ga, gb, gc;
    {ga, gb, gc} = v;
    return {(ga & gc) | (~ga & gb), (ga | ~gc) & gb & gc};
  endfunction

  // The vector flops drive the datapath inputs directly.
  assign {a, b, c} = vec;

  // Mismatches on the current vector (0..2) and the resulting running total.
  always_comb begin
    golden   = golden_out(vec);
    mism     = 5'(o1 != golden[1]) + 5'(o2 != golden[0]);
    err_next = err_count + mism;
  end

  // Sequencer: state, vector stepping, settle timing, and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      vec            <= 3'd0;
      settle_cnt     <= 4'd0;
      seen_fail      <= 1'b0;
      err_count      <= 5'd0;
      first_fail_vec <= 3'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec            <= 3'd0;
            settle_cnt     <= 4'd0;
            err_count      <= 5'd0;
            first_fail_vec <= 3'd0;
            seen_fail      <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            state          <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
            state      <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CHECK: begin
          err_count <= err_next;
          if ((mism != 5'd0) && !seen_fail) begin
            first_fail_vec <= vec;
            seen_fail      <= 1'b1;
          end
          if (vec == 3'd7) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 5'd0);
            state <= DONE;
          end else begin
            vec   <= vec + 3'd1;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_functions_tester.sv
// Directed bench for logic_functions_tester. A behavioural logic_functions
// model with selectable faults is attached to two instances of the tester:
// the default settle time and SETTLE_CYCLES=1.
module tb_logic_functions_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with default settle time
  logic       reset_n, start, o1, o2, a, b, c, busy, done, pass;
  logic [4:0] err_count;
  logic [2:0] first_fail_vec;
  int         mode;

  // Instance with SETTLE_CYCLES=1
  logic       reset_n1, start1, o1_1, o2_1, a1, b1, c1, busy1, done1, pass1;
  logic [4:0] err_count1;
  logic [2:0] first_fail_vec1;
  int         mode1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic_functions_tester u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .o1(o1), .o2(o2),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_vec(first_fail_vec)
  );

  logic_functions_tester #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n1), .start(start1), .o1(o1_1), .o2(o2_1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .first_fail_vec(first_fail_vec1)
  );

  // Behavioural logic_functions. mode: 0 good, 1 O2 stuck-0, 2 O1 stuck-0, 3 both inverted.
  function automatic logic [1:0] lf_model(input logic ma, mb, mc, input int m);
    logic g1, g2;
    g1 = (ma & mc) | (~ma & mb);
    g2 = (ma | ~mc) & mb & mc;
    case (m)
      1: g2 = 1'b0;
      2: g1 = 1'b0;
      3: begin g1 = ~g1; g2 = ~g2; end
      default: ;
    endcase
    return {g1, g2};
  endfunction

  always_comb {o1, o2}     = lf_model(a, b, c, mode);
  always_comb {o1_1, o2_1} = lf_model(a1, b1, c1, mode1);

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start on the default instance and wait for done. It reports the
  // edge count at which done appeared and whether vectors stepped as expected.
  task automatic run0(output int edges, output logic order_ok);
    int exp_v;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges    = 0;
    order_ok = 1'b1;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      exp_v = (edges / 3 > 7) ? 7 : edges / 3;
      if ({a, b, c} != 3'(exp_v)) order_ok = 1'b0;
      if (done) break;
    end
  endtask

  int   edges;
  logic order_ok;

  initial begin
    reset_n  = 1'b0; start  = 1'b0; mode  = 0;
    reset_n1 = 1'b0; start1 = 1'b0; mode1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outs", int'({a, b, c, busy, done, pass}), 0);
    check_eq("reset_err", int'(err_count), 0);
    check_eq("reset_ffv", int'(first_fail_vec), 0);
    check_eq("reset_outs1", int'({a1, b1, c1, busy1, done1, pass1, err_count1}), 0);
    reset_n = 1'b1; reset_n1 = 1'b1;

    // Scenario 1: good block
    mode = 0;
    run0(edges, order_ok);
    check_eq("s1_done_edge", edges, 24);
    check_eq("s1_vec_order", int'(order_ok), 1);
    check_eq("s1_pass", int'(pass), 1);
    check_eq("s1_err", int'(err_count), 0);
    check_eq("s1_busy", int'(busy), 0);

    // Scenario 2: O2 stuck at 0 (restart from DONE)
    mode = 1;
    run0(edges, order_ok);
    check_eq("s2_done_edge", edges, 24);
    check_eq("s2_err", int'(err_count), 1);
    check_eq("s2_ffv", int'(first_fail_vec), 7);
    check_eq("s2_pass", int'(pass), 0);

    // Scenario 3: O1 stuck at 0
    mode = 2;
    run0(edges, order_ok);
    check_eq("s3_err", int'(err_count), 4);
    check_eq("s3_ffv", int'(first_fail_vec), 2);
    check_eq("s3_pass", int'(pass), 0);

    // Scenario 4: both outputs inverted
    mode = 3;
    run0(edges, order_ok);
    check_eq("s4_err", int'(err_count), 16);
    check_eq("s4_ffv", int'(first_fail_vec), 0);
    check_eq("s4_pass", int'(pass), 0);
    check_eq("s4_done", int'(done), 1);

    // Scenario 5: abort during vector 4 with reset, then rerun
    mode = 3;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0;
    while (edges < 50 && {a, b, c} != 3'd4) begin
      @(posedge clk);
      edges++;
      #1;
    end
    check_eq("s5_reach_vec4", edges, 12);
    check_eq("s5_pre_abort_err", int'(err_count), 8);
    #2 reset_n = 1'b0;
    #1;
    check_eq("s5_abort_outs", int'({a, b, c, busy, done, pass, err_count, first_fail_vec}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    mode = 0;
    run0(edges, order_ok);
    check_eq("s5_rerun_done_edge", edges, 24);
    check_eq("s5_rerun_vec_order", int'(order_ok), 1);
    check_eq("s5_rerun_pass", int'(pass), 1);
    check_eq("s5_rerun_err", int'(err_count), 0);

    // Scenario 6: SETTLE_CYCLES=1 with start pulses during busy
    mode1 = 3;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      start1 = (edges == 3 || edges == 7);
      if (done1) break;
    end
    start1 = 1'b0;
    check_eq("s6_done_edge", edges, 16);
    check_eq("s6_err", int'(err_count1), 16);
    check_eq("s6_pass", int'(pass1), 0);
    mode1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    check_eq("s6_restart_done", int'(done1), 0);
    check_eq("s6_restart_err", int'(err_count1), 0);
    check_eq("s6_restart_busy", int'(busy1), 1);
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (done1) break;
    end
    check_eq("s6_rerun_done_edge", edges, 16);
    check_eq("s6_rerun_pass", int'(pass1), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
